// File: rtl/uniq_arb.sv
// Round-robin arbiter feeding a single output register for a downstream unique-value tracker.
// Zero values are accepted and dropped; flush drains the output register before resuming.
module uniq_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic        flush,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_en,
    output logic [1:0]  grant_id,
    output logic        flush_done,
    output logic [15:0] fwd_cnt,
    output logic [7:0]  drop_cnt
);

    typedef enum logic {StRun, StDrain} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [1:0]  r_ptr;
    logic [7:0]  r_out_data;
    logic        r_out_en;
    logic [1:0]  r_grant_id;
    logic [15:0] r_fwd_cnt;
    logic [7:0]  r_drop_cnt;

    logic        w_free;
    logic        w_xfer;
    logic        w_found;
    logic [1:0]  w_idx;
    logic [1:0]  w_gidx;
    logic        w_grant;
    logic [7:0]  w_gdata;
    logic        w_load;
    logic        w_drop;

    assign w_free = !r_out_en || out_ready;
    assign w_xfer = r_out_en && out_ready;

    // First valid requester at or after the pointer, wrapping mod 4.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    // rst_n gates the grant so req_ready stays low throughout reset.
    assign w_grant   = rst_n && (r_state == StRun) && !flush && w_free && w_found;
    assign req_ready = w_grant ? (4'b0001 << w_gidx) : 4'b0000;
    assign w_gdata   = req_data[8*w_gidx +: 8];
    assign w_load    = w_grant && (w_gdata != 8'd0);
    assign w_drop    = w_grant && (w_gdata == 8'd0);

    assign flush_done = (r_state == StDrain) && w_free;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StRun:   if (flush)  w_state_nxt = StDrain;
            StDrain: if (w_free) w_state_nxt = StRun;
            default: w_state_nxt = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StRun;
            r_ptr      <= 2'd0;
            r_out_data <= 8'd0;
            r_out_en   <= 1'b0;
            r_grant_id <= 2'd0;
            r_fwd_cnt  <= 16'd0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_ptr <= w_gidx + 2'd1;
            end
            if (w_load) begin
                r_out_data <= w_gdata;
                r_grant_id <= w_gidx;
                r_out_en   <= 1'b1;
            end else if (w_xfer) begin
                r_out_en <= 1'b0;
            end
            if (w_xfer && (r_fwd_cnt != 16'hFFFF)) begin
                r_fwd_cnt <= r_fwd_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign out_data = r_out_data;
    assign out_en   = r_out_en;
    assign grant_id = r_grant_id;
    assign fwd_cnt  = r_fwd_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uniq_arb.sv
// Bench for uniq_arb: directed vector table, hand-written corner sequences and random stimulus
// checked against a cycle-level behavioural model.
module tb_uniq_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_data = 32'd0;
    logic [3:0]  req_valid = 4'd0;
    logic [3:0]  req_ready;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_en;
    logic [1:0]  grant_id;
    logic        flush_done;
    logic [15:0] fwd_cnt;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    int m_ptr, m_en, m_data, m_gid, m_fwd, m_drop, m_drain;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_en;
        logic [7:0]  exp_data;
        logic [1:0]  exp_gid;
        logic [15:0] exp_fwd;
    } vec_t;

    vec_t tbl[6];

    uniq_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_en     (out_en),
        .grant_id   (grant_id),
        .flush_done (flush_done),
        .fwd_cnt    (fwd_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int grant_of();
        if (m_drain != 0 || flush || !(m_en == 0 || out_ready)) return -1;
        for (int k = 0; k < 4; k++) begin
            if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_en = 0; m_data = 0; m_gid = 0; m_fwd = 0; m_drop = 0; m_drain = 0;
    endtask

    task automatic model_check();
        int g;
        g = grant_of();
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("out_en", 32'(out_en), 32'(m_en));
        if (m_en != 0) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
        end
        chk("fwd_cnt", 32'(fwd_cnt), 32'(m_fwd));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("flush_done", 32'(flush_done), 32'((m_drain != 0) && (m_en == 0 || out_ready)));
    endtask

    task automatic model_update();
        int g, v;
        bit xfer, free;
        g    = grant_of();
        xfer = (m_en != 0) && out_ready;
        free = (m_en == 0) || out_ready;
        if (xfer && m_fwd < 65535) m_fwd++;
        if (g >= 0) begin
            m_ptr = (g + 1) % 4;
            v = int'(req_data[8*g +: 8]);
            if (v != 0) begin
                m_data = v; m_gid = g; m_en = 1;
            end else begin
                if (m_drop < 255) m_drop++;
                if (xfer) m_en = 0;
            end
        end else if (xfer) begin
            m_en = 0;
        end
        if (m_drain != 0 && free) m_drain = 0;
        else if (m_drain == 0 && flush) m_drain = 1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Assert reset mid-cycle, check the immediate clear, release after one edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_en", 32'(out_en), 32'd0);
        chk("rst_fwd_cnt", 32'(fwd_cnt), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{4'hF, 32'h08070605, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 16'd0};
        tbl[1] = '{4'hF, 32'h08070605, 1'b1, 4'b0010, 1'b1, 8'h05, 2'd0, 16'd0};
        tbl[2] = '{4'hF, 32'h08070605, 1'b1, 4'b0100, 1'b1, 8'h06, 2'd1, 16'd1};
        tbl[3] = '{4'hF, 32'h08070605, 1'b1, 4'b1000, 1'b1, 8'h07, 2'd2, 16'd2};
        tbl[4] = '{4'hF, 32'h08070605, 1'b1, 4'b0001, 1'b1, 8'h08, 2'd3, 16'd3};
        tbl[5] = '{4'hF, 32'h08070605, 1'b1, 4'b0010, 1'b1, 8'h05, 2'd0, 16'd4};

        req_valid = 4'hF;
        #2;
        apply_reset();

        // Round-robin over four valid requesters, full throughput.
        for (int i = 0; i < 6; i++) begin
            req_valid = tbl[i].valid; req_data = tbl[i].data; out_ready = tbl[i].ordy;
            at_neg();
            chk("tbl_ready", 32'(req_ready), 32'(tbl[i].exp_ready));
            chk("tbl_en", 32'(out_en), 32'(tbl[i].exp_en));
            if (tbl[i].exp_en) begin
                chk("tbl_data", 32'(out_data), 32'(tbl[i].exp_data));
                chk("tbl_gid", 32'(grant_id), 32'(tbl[i].exp_gid));
            end
            chk("tbl_fwd", 32'(fwd_cnt), 32'(tbl[i].exp_fwd));
            at_pos();
        end

        // Mid-cycle reset while holding a value with fwd_cnt=3; pointer restarts at 0.
        apply_reset();
        for (int i = 0; i < 4; i++) begin at_neg(); at_pos(); end
        chk("pre_rst_fwd", 32'(fwd_cnt), 32'd3);
        chk("pre_rst_en", 32'(out_en), 32'd1);
        apply_reset();
        at_neg();
        chk("post_rst_ptr", 32'(req_ready), 32'b0001);
        at_pos();

        // Zero from requester 2 is dropped, then 9 is forwarded.
        apply_reset();
        req_valid = 4'b0100; req_data = 32'h0000_0000; out_ready = 1'b1;
        at_neg();
        chk("zero_ready", 32'(req_ready), 32'b0100);
        at_pos();
        req_data = 32'h0009_0000;
        at_neg();
        chk("zero_drop", 32'(drop_cnt), 32'd1);
        chk("zero_en", 32'(out_en), 32'd0);
        chk("nine_ready", 32'(req_ready), 32'b0100);
        at_pos();
        req_valid = 4'b0000;
        at_neg();
        chk("nine_data", 32'(out_data), 32'h09);
        chk("nine_gid", 32'(grant_id), 32'd2);
        at_pos();

        // Backpressure: 0x11 held for three cycles, then the next value follows.
        apply_reset();
        req_valid = 4'b0001; req_data = 32'h4433_2211; out_ready = 1'b1;
        at_neg(); at_pos();
        req_valid = 4'hF; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("bp_data", 32'(out_data), 32'h11);
            chk("bp_gid", 32'(grant_id), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
            at_pos();
        end
        out_ready = 1'b1;
        at_neg(); at_pos();
        at_neg();
        chk("bp_next", 32'(out_data), 32'h22);
        at_pos();

        // Flush while 0x22 is held under backpressure; flush during DRAIN is ignored.
        apply_reset();
        req_valid = 4'b0001; req_data = 32'h0000_0022; out_ready = 1'b1;
        at_neg(); at_pos();
        req_valid = 4'hF; req_data = 32'h0403_0222; out_ready = 1'b0; flush = 1'b1;
        at_neg(); at_pos();
        at_neg();
        chk("drain_ready", 32'(req_ready), 32'd0);
        chk("drain_fd", 32'(flush_done), 32'd0);
        at_pos();
        flush = 1'b0; out_ready = 1'b1;
        at_neg();
        chk("drain_done", 32'(flush_done), 32'd1);
        chk("drain_ready2", 32'(req_ready), 32'd0);
        at_pos();
        at_neg();
        chk("drain_fd_low", 32'(flush_done), 32'd0);
        chk("drain_fwd", 32'(fwd_cnt), 32'd1);
        chk("resume_ready", 32'(req_ready), 32'b0010);
        at_pos();

        // Flush with an empty output register: one cycle in DRAIN.
        apply_reset();
        req_valid = 4'd0; flush = 1'b1;
        at_neg(); at_pos();
        flush = 1'b0;
        at_neg();
        chk("empty_flush_done", 32'(flush_done), 32'd1);
        at_pos();
        at_neg();
        at_pos();

        // Random traffic.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom);
            req_data  = $urandom;
            if ($urandom_range(3) == 0) req_data[8*$urandom_range(3) +: 8] = 8'd0;
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(19) == 0);
            at_neg(); at_pos();
        end
        flush = 1'b0;

        // drop_cnt saturation.
        apply_reset();
        req_valid = 4'hF; req_data = 32'd0; out_ready = 1'b1;
        for (int i = 0; i < 260; i++) at_pos();
        at_neg();
        chk("drop_sat", 32'(drop_cnt), 32'hFF);
        at_pos();

        // fwd_cnt saturation.
        apply_reset();
        req_data = 32'h0101_0101;
        for (int i = 0; i < 65540; i++) at_pos();
        at_neg();
        chk("fwd_sat", 32'(fwd_cnt), 32'hFFFF);
        at_pos();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uniq_arb.md
UNIQ_ARB -- requirements
Module: uniq_arb

Interface
REQ-001 The block SHALL expose exactly the following ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_data  input  32  four signed 8-bit requester values; requester i on bits [8i+7:8i].
- req_valid  input  4  per-requester valid; bit i belongs to requester i.
- req_ready  output  4  per-requester accept strobe; combinational; one-hot or zero.
- flush  input  1  drain request, sampled each cycle.
- out_ready  input  1  downstream datapath can take a value this cycle.
- out_data  output  8  signed value presented to the downstream unique-value tracker (its data_in).
- out_en  output  1  out_data valid (the tracker's data_en).
- grant_id  output  2  index of the requester whose value sits in the output register.
- flush_done  output  1  one-cycle pulse when a drain completes.
- fwd_cnt  output  16  count of values forwarded downstream; saturating.
- drop_cnt  output  8  count of zero values dropped; saturating.

Function
REQ-002 The block SHALL hold one output register (out_data, grant_id, out_en); a transfer occurs on a rising edge where out_en=1 and out_ready=1.
REQ-003 The output register SHALL count as free in a cycle where out_en=0 or a transfer occurs.
REQ-004 A grant SHALL be issued only in state RUN, only when the output register is free, and only to a requester with req_valid=1.
REQ-005 Arbitration SHALL be round-robin: the search starts at pointer p and proceeds p, p+1, p+2, p+3 mod 4; the first valid requester wins.
REQ-006 After any grant to requester i, p SHALL become (i+1) mod 4; p SHALL be unchanged in cycles with no grant.
REQ-007 req_ready[i] SHALL be 1 exactly in the cycle requester i is granted; the value is consumed on that rising edge.
REQ-008 A granted value not equal to 0 SHALL be loaded into out_data with grant_id=i and out_en=1 at the next edge; latency from accept to out_en is one cycle.
REQ-009 Zero is reserved as "invalid" downstream: a granted value of 0 SHALL be accepted (req_ready=1), not forwarded, and SHALL increment drop_cnt.
REQ-010 A zero drop SHALL still advance p per REQ-006.
REQ-011 If a transfer occurs and no non-zero grant is made that cycle, out_en SHALL go to 0 at that edge.
REQ-012 A transfer together with a non-zero grant in the same cycle SHALL give back-to-back output with out_en staying 1 (full throughput, one value per cycle).
REQ-013 While out_en=1 and out_ready=0, out_data and grant_id SHALL stay stable and no grant SHALL be issued.
REQ-014 fwd_cnt SHALL increment on each transfer and saturate at 16'hFFFF.
REQ-015 drop_cnt SHALL saturate at 8'hFF.
REQ-016 The FSM SHALL have two states, RUN and DRAIN.
REQ-017 In RUN, flush=1 SHALL move the FSM to DRAIN at the next edge and SHALL suppress any grant in that same cycle (flush wins).
REQ-018 In DRAIN, no grants SHALL be issued and req_ready SHALL be 0.
REQ-019 The FSM SHALL leave DRAIN for RUN in the first cycle the output register is free; flush_done SHALL pulse 1 for exactly that cycle.
REQ-020 flush asserted while in DRAIN SHALL be ignored.
REQ-021 A flush in RUN with the output register already empty SHALL take one cycle in DRAIN, then flush_done pulses.

Reset
REQ-022 On rst_n=0 the following SHALL clear immediately, independent of clk: out_data=0, out_en=0, grant_id=0, flush_done=0, fwd_cnt=0, drop_cnt=0; p=0; state=RUN.
REQ-023 While rst_n=0, req_ready SHALL be 0.
REQ-024 A reset asserted while a value is held SHALL discard that value, with no transfer and no counter change.
REQ-025 After rst_n deassertion, the first grant SHALL be possible on the first rising edge.

Verification
REQ-026 All four requesters valid with values 5, 6, 7, 8 and out_ready=1 -> grants in order 0, 1, 2, 3, 0; out_data sequence 5, 6, 7, 8 on consecutive cycles; fwd_cnt=4 after four transfers.
REQ-027 Requester 2 sends 0, then 9 -> first grant gives req_ready[2]=1 with out_en unchanged and drop_cnt=1; next grant forwards 9 with grant_id=2.
REQ-028 out_ready held 0 for 3 cycles with out_data=0x11 held -> out_data and grant_id stable, req_ready=0; after out_ready=1, next value appears the following cycle.
REQ-029 flush pulsed while 0x22 held and out_ready=0 -> state DRAIN, no grants; out_ready=1 -> transfer of 0x22, flush_done=1 for one cycle, granting resumes.
REQ-030 rst_n pulled low mid-cycle with out_en=1 and fwd_cnt=3 -> out_en, fwd_cnt and grant_id read 0 before the next clk edge; p restarts at 0.
REQ-031 fwd_cnt preloaded by driving 65535 transfers, then one more -> fwd_cnt stays 16'hFFFF.
